// File: rtl/mult_div_engine.sv
// mult_div_engine: MIPS-style HI/LO multiply/divide unit.
// The result is computed at the accepted start edge and parked in pendHi/pendLo.
// It is committed to HI/LO once a fixed countdown expires, which models the
// latency of a real iterative unit. MTHI/MTLO write HI/LO directly.
// MFHI/MFLO read the committed values through a combinational mux.
module mult_div_engine #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] operand1,
  input  logic [31:0] operand2,
  input  logic [3:0]  operation,
  input  logic        start,
  output logic        busy,
  output logic [31:0] dataRead
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MUL_RUN = 2'd1,
    DIV_RUN = 2'd2
  } state_t;

  state_t      state_r, nextState_s;
  logic [3:0]  count_r, nextCount_s;
  logic [31:0] hi_r, nextHi_s;
  logic [31:0] lo_r, nextLo_s;
  logic [31:0] pendHi_r, nextPendHi_s;
  logic [31:0] pendLo_r, nextPendLo_s;
  logic        divZero_r, nextDivZero_s;
  logic [63:0] mulS_s, mulU_s, divS_s, divU_s;

  // Signed 32x32 product, full 64-bit result {hi, lo}.
  function automatic logic [63:0] mulSigned(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea;
    logic [63:0] eb;
    ea = {{32{a[31]}}, a};
    eb = {{32{b[31]}}, b};
    return ea * eb;
  endfunction

  // Unsigned 32x32 product, full 64-bit result {hi, lo}.
  function automatic logic [63:0] mulUnsigned(input logic [31:0] a, input logic [31:0] b);
    return {32'd0, a} * {32'd0, b};
  endfunction

  // Signed divide on magnitudes so that 0x80000000 / -1 wraps cleanly.
  // Returns {remainder, quotient}. The quotient truncates toward zero and the
  // remainder takes the sign of the dividend. A zero divisor returns zeros,
  // because the caller suppresses the commit in that case.
  function automatic logic [63:0] divSigned(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] magA;
    logic [31:0] magB;
    logic [31:0] q;
    logic [31:0] r;
    magA = a[31] ? (32'd0 - a) : a;
    magB = b[31] ? (32'd0 - b) : b;
    if (magB == 32'd0) begin
      q = 32'd0;
      r = 32'd0;
    end else begin
      q = magA / magB;
      r = magA % magB;
    end
    if (a[31] ^ b[31]) begin
      q = 32'd0 - q;
    end else begin
      q = q;
    end
    if (a[31]) begin
      r = 32'd0 - r;
    end else begin
      r = r;
    end
    return {r, q};
  endfunction

  // Unsigned divide, returns {remainder, quotient}; a zero divisor yields zeros.
  function automatic logic [63:0] divUnsigned(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] res;
    if (b == 32'd0) begin
      res = 64'd0;
    end else begin
      res = {a % b, a / b};
    end
    return res;
  endfunction

  assign mulS_s = mulSigned(operand1, operand2);
  assign mulU_s = mulUnsigned(operand1, operand2);
  assign divS_s = divSigned(operand1, operand2);
  assign divU_s = divUnsigned(operand1, operand2);

  // Next-state logic: accept start only in IDLE, count down while running, commit at expiry.
  always_comb begin
    nextState_s   = state_r;
    nextCount_s   = count_r;
    nextHi_s      = hi_r;
    nextLo_s      = lo_r;
    nextPendHi_s  = pendHi_r;
    nextPendLo_s  = pendLo_r;
    nextDivZero_s = divZero_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          case (operation)
            OP_MULT: begin
              {nextPendHi_s, nextPendLo_s} = mulS_s;
              nextCount_s   = MULT_LOAD;
              nextDivZero_s = 1'b0;
              nextState_s   = MUL_RUN;
            end
            OP_MULTU: begin
              {nextPendHi_s, nextPendLo_s} = mulU_s;
              nextCount_s   = MULT_LOAD;
              nextDivZero_s = 1'b0;
              nextState_s   = MUL_RUN;
            end
            OP_DIV: begin
              {nextPendHi_s, nextPendLo_s} = divS_s;
              nextCount_s   = DIV_LOAD;
              nextDivZero_s = (operand2 == 32'd0);
              nextState_s   = DIV_RUN;
            end
            OP_DIVU: begin
              {nextPendHi_s, nextPendLo_s} = divU_s;
              nextCount_s   = DIV_LOAD;
              nextDivZero_s = (operand2 == 32'd0);
              nextState_s   = DIV_RUN;
            end
            OP_MTHI: nextHi_s = operand1;
            OP_MTLO: nextLo_s = operand1;
            default: nextState_s = IDLE;
          endcase
        end else begin
          nextState_s = IDLE;
        end
      end
      MUL_RUN, DIV_RUN: begin
        nextCount_s = count_r - 4'd1;
        if (count_r == 4'd1) begin
          nextState_s = IDLE;
          if (!divZero_r) begin
            nextHi_s = pendHi_r;
            nextLo_s = pendLo_r;
          end else begin
            nextHi_s = hi_r;
          end
        end else begin
          nextState_s = state_r;
        end
      end
      default: begin
        nextState_s = IDLE;
        nextCount_s = 4'd0;
      end
    endcase
  end

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r   <= IDLE;
      count_r   <= 4'd0;
      hi_r      <= 32'd0;
      lo_r      <= 32'd0;
      pendHi_r  <= 32'd0;
      pendLo_r  <= 32'd0;
      divZero_r <= 1'b0;
    end else begin
      state_r   <= nextState_s;
      count_r   <= nextCount_s;
      hi_r      <= nextHi_s;
      lo_r      <= nextLo_s;
      pendHi_r  <= nextPendHi_s;
      pendLo_r  <= nextPendLo_s;
      divZero_r <= nextDivZero_s;
    end
  end

  assign busy = (state_r != IDLE);

  // Read mux over committed HI/LO only.
  always_comb begin
    case (operation)
      OP_MFHI: dataRead = hi_r;
      OP_MFLO: dataRead = lo_r;
      default: dataRead = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_mult_div_engine.sv
// Self-checking bench for mult_div_engine: directed scenarios plus randomized
// operations checked against an arithmetic HI/LO reference model.
module tb_mult_div_engine;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] operand1 = 32'd0;
  logic [31:0] operand2 = 32'd0;
  logic [3:0]  operation = 4'd0;
  logic        start = 1'b0;
  logic        busy;
  logic [31:0] dataRead;

  int checks = 0;
  int errors = 0;
  logic [31:0] mHi = 32'd0;
  logic [31:0] mLo = 32'd0;
  int cnt;

  mult_div_engine #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clock(clock), .reset(reset), .operand1(operand1), .operand2(operand2),
    .operation(operation), .start(start), .busy(busy), .dataRead(dataRead)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: effect of an accepted operation on HI/LO.
  task automatic modelApply(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, p, q, r;
    longint unsigned ua, ub, up, uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      4'd1: begin p = sa * sb; mHi = p[63:32]; mLo = p[31:0]; end
      4'd2: begin up = ua * ub; mHi = up[63:32]; mLo = up[31:0]; end
      4'd3: if (b != 32'd0) begin q = sa / sb; r = sa % sb; mHi = r[31:0]; mLo = q[31:0]; end
      4'd4: if (b != 32'd0) begin uq = ua / ub; ur = ua % ub; mHi = ur[31:0]; mLo = uq[31:0]; end
      4'd7: mHi = a;
      4'd8: mLo = a;
      default: ;
    endcase
  endtask

  function automatic int expCycles(input logic [3:0] op);
    if (op == 4'd1 || op == 4'd2) return 5;
    if (op == 4'd3 || op == 4'd4) return 10;
    return 0;
  endfunction

  // Compare HI/LO read through MFHI/MFLO with the given values (called at negedge).
  task automatic readHiLo(input string tag, input logic [31:0] eh, input logic [31:0] el);
    start = 1'b0;
    operation = 4'd5; #1;
    check({tag, ".hi"}, dataRead, eh);
    operation = 4'd6; #1;
    check({tag, ".lo"}, dataRead, el);
    operation = 4'd0; #1;
  endtask

  // Issue one operation at a negedge, count busy cycles, return at first idle negedge.
  task automatic runOp(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    operation = op; operand1 = a; operand2 = b; start = 1'b1;
    modelApply(op, a, b);
    @(negedge clock);
    start = 1'b0; operation = 4'd0;
    operand1 = $urandom; operand2 = $urandom;
    cnt = 0;
    while (busy && cnt < 40) begin
      cnt++;
      @(negedge clock);
    end
    check({tag, ".busyCycles"}, 32'(cnt), 32'(expCycles(op)));
  endtask

  initial begin
    logic [3:0]  rop;
    logic [31:0] ra, rb;

    // Reset.
    repeat (2) @(negedge clock);
    reset = 1'b0;
    check("reset.busy", {31'd0, busy}, 32'd0);
    readHiLo("reset", 32'd0, 32'd0);

    // Multiply, signed then unsigned.
    runOp("mult", 4'd1, 32'hFFFFFFFE, 32'h00000003);
    readHiLo("mult", 32'hFFFFFFFF, 32'hFFFFFFFA);
    runOp("multu", 4'd2, 32'hFFFFFFFE, 32'h00000003);
    readHiLo("multu", 32'h00000002, 32'hFFFFFFFA);

    // Divide cases, including the overflow corner.
    runOp("div", 4'd3, 32'hFFFFFFF9, 32'd2);
    readHiLo("div", 32'hFFFFFFFF, 32'hFFFFFFFD);
    runOp("divu", 4'd4, 32'd7, 32'd2);
    readHiLo("divu", 32'd1, 32'd3);
    runOp("divOvf", 4'd3, 32'h80000000, 32'hFFFFFFFF);
    readHiLo("divOvf", 32'h00000000, 32'h80000000);

    // MTHI: HI still old in the issue cycle, new the next cycle, busy never rises.
    operation = 4'd5; #1;
    check("mthi.before", dataRead, 32'd0);
    runOp("mthi", 4'd7, 32'h12345678, 32'd0);
    operation = 4'd5; #1;
    check("mthi.after", dataRead, 32'h12345678);
    runOp("mtlo", 4'd8, 32'h000000AA, 32'd0);
    runOp("divu0", 4'd4, 32'h55555555, 32'd0);
    readHiLo("divu0", 32'h12345678, 32'h000000AA);

    // Start while busy is ignored; result comes from original operands.
    operation = 4'd1; operand1 = 32'd7; operand2 = 32'hFFFFFFFD; start = 1'b1;
    modelApply(4'd1, 32'd7, 32'hFFFFFFFD);
    @(negedge clock);
    cnt = 0;
    while (busy && cnt < 40) begin
      cnt++;
      if (cnt == 2) begin
        operation = 4'd3; operand1 = 32'd100; operand2 = 32'd5; start = 1'b1;
      end else begin
        operation = 4'd0; operand1 = $urandom; operand2 = $urandom; start = 1'b0;
      end
      @(negedge clock);
    end
    start = 1'b0;
    check("ignore.busyCycles", 32'(cnt), 32'd5);
    readHiLo("ignore", 32'hFFFFFFFF, 32'hFFFFFFEB);

    // Reset mid-divide aborts without commit.
    operation = 4'd3; operand1 = 32'd1000; operand2 = 32'd7; start = 1'b1;
    @(negedge clock);
    start = 1'b0; operation = 4'd0;
    cnt = 0;
    while (busy && cnt < 4) begin
      cnt++;
      if (cnt < 4) @(negedge clock);
    end
    check("abort.reachedCycle4", 32'(cnt), 32'd4);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    mHi = 32'd0; mLo = 32'd0;
    check("abort.busy", {31'd0, busy}, 32'd0);
    readHiLo("abort", 32'd0, 32'd0);
    runOp("postReset", 4'd2, 32'd3, 32'd4);
    readHiLo("postReset", 32'd0, 32'd12);

    // Back-to-back: the next start is issued on the cycle busy falls.
    runOp("b2b1", 4'd2, 32'd2, 32'd3);
    operation = 4'd6; #1;
    check("b2b1.loOnFall", dataRead, 32'd6);
    runOp("b2b2", 4'd2, 32'd5, 32'd5);
    operation = 4'd6; #1;
    check("b2b2.lo", dataRead, 32'd25);

    // Randomized operations against the reference model.
    for (int i = 0; i < 30; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 9));
      runOp("rand", rop, ra, rb);
      readHiLo("rand", mHi, mLo);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_div_engine.md
MULT_DIV_ENGINE -- requirements
Module: mult_div_engine

Interface
REQ-001 The block SHALL have parameter MULT_CYCLES, default 5, giving busy cycles for MULT/MULTU (legal range 1..15).
REQ-002 The block SHALL have parameter DIV_CYCLES, default 10, giving busy cycles for DIV/DIVU (legal range 1..15).
REQ-003 The block SHALL have port clock, input, 1, the rising-edge clock.
REQ-004 The block SHALL have port reset, input, 1, with reset synchronous and active-high.
REQ-005 The block SHALL have port operand1, input, 32, giving rs data (multiplicand/dividend; source for MTHI/MTLO).
REQ-006 The block SHALL have port operand2, input, 32, giving rt data (multiplier/divisor).
REQ-007 The block SHALL have port operation, input, 4, encoded 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO; 9-15 are treated as NONE.
REQ-008 The block SHALL have port start, input, 1, as a single-cycle request to execute operation; the initiator gates it with its own stall.
REQ-009 The block SHALL have port busy, output, 1, which is high while a MULT/DIV is in flight; the initiator stalls on it.
REQ-010 The block SHALL have port dataRead, output, 32, carrying combinational HI/LO read data for MFHI/MFLO.

Function
REQ-011 The block SHALL hold architectural registers HI and LO (32 bits each), a 4-bit countdown counter, pending registers pendHI/pendLO, and a state machine with states IDLE, MUL_RUN, DIV_RUN.
REQ-012 The block SHALL drive busy = (state != IDLE), decoded from registered state only, with no combinational path from start.
REQ-013 In IDLE, start with MULT SHALL: set pendHI:pendLO to the signed 64-bit product operand1*operand2; load the counter with MULT_CYCLES; enter MUL_RUN at the same edge.
REQ-014 MULTU SHALL behave as REQ-013 with an unsigned product.
REQ-015 In IDLE, start with DIV SHALL: set pendLO to the signed quotient truncated toward zero; set pendHI to the remainder, which takes the sign of the dividend; load the counter with DIV_CYCLES; enter DIV_RUN.
REQ-016 DIVU SHALL behave as REQ-015 with unsigned quotient and remainder.
REQ-017 DIV with 0x80000000 / 0xFFFFFFFF SHALL yield LO=0x80000000 and HI=0x00000000.
REQ-018 DIV or DIVU with operand2==0 SHALL still run DIV_CYCLES, after which HI and LO are unchanged.
REQ-019 In MUL_RUN or DIV_RUN, the counter SHALL decrement every cycle.
REQ-020 On the edge where the counter goes 1->0, the block SHALL copy HI<=pendHI and LO<=pendLO (unless REQ-018 applies) and return to IDLE.
REQ-021 After the start edge, busy SHALL be high for exactly MULT_CYCLES or DIV_CYCLES cycles.
REQ-022 In IDLE, start with MTHI SHALL write HI<=operand1 at that edge, and start with MTLO SHALL write LO<=operand1 at that edge; busy stays low.
REQ-023 MFHI, MFLO and NONE SHALL cause no state change, regardless of start.
REQ-024 The block SHALL drive dataRead = HI when operation==MFHI, LO when operation==MFLO, and 0 otherwise, regardless of start or busy.
REQ-025 dataRead SHALL reflect committed HI/LO only, never pending values.
REQ-026 Start asserted while busy SHALL be ignored entirely: no operand capture, no counter reload, no HI/LO write.
REQ-027 On the cycle busy falls, dataRead SHALL already show the new HI/LO.
REQ-028 A start in that cycle (state IDLE) SHALL be accepted normally, giving back-to-back operations with no dead cycle.
REQ-029 Operands SHALL be sampled only at the accepted start edge; operand changes during the run SHALL NOT affect the result.

Reset
REQ-030 With reset high at a rising edge, the block SHALL set HI=0, LO=0, pendHI=pendLO=0, counter=0 and state=IDLE; busy is 0 from the following cycle.
REQ-031 Reset SHALL take priority over start.
REQ-032 Reset mid-operation SHALL abort the operation with no HI/LO commit.
REQ-033 After reset, start SHALL be accepted on the first cycle in which reset is low.

Verification
REQ-034 The bench SHALL cover: MULT 0xFFFFFFFE*0x00000003 -> busy high exactly 5 cycles; then MFHI gives 0xFFFFFFFF and MFLO gives 0xFFFFFFFA. Same operands with MULTU -> HI=0x00000002, LO=0xFFFFFFFA.
REQ-035 The bench SHALL cover: DIV 0xFFFFFFF9 (-7) / 2 -> busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/2 -> LO=3, HI=1. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-036 The bench SHALL cover: MTHI 0x12345678 with HI=0 before; MFHI with start=0 in the same cycle reads 0; next cycle MFHI reads 0x12345678; busy never rises. DIVU x/0 after MTLO 0xAA -> after 10 cycles LO=0xAA, HI=0x12345678.
REQ-037 The bench SHALL cover: MULT started, then start=1 with DIV pulsed on cycle 2 of busy, with operand changes -> ignored; busy total is 5 and the result is from the original operands.
REQ-038 The bench SHALL cover: DIV started, reset asserted at busy cycle 4 -> busy 0 the next cycle, HI=LO=0, dataRead(MFLO)=0; a new MULTU 3*4 then completes with LO=12 after 5 cycles.
REQ-039 The bench SHALL cover: back-to-back MULTU 2*3 then MULTU 5*5 started on the cycle busy falls -> MFLO shows 6 on that cycle, then 25 five cycles later; no idle cycle between busy periods.
